// File: rtl/alu_frame_ctrl.sv
// Frame sequencer between UART RX/TX and the ALU: gathers A, B, opcode, waits for
// the ALU to settle, then hands the result to TX with a start/active/done handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------
// GET_A     | idle, waiting for operand A byte
// GET_B     | waiting for operand B byte (watchdog running)
// GET_OP    | waiting for opcode byte (watchdog running)
// SETTLE    | operands stable, counting down ALU latency
// LAUNCH    | o_tx_start held until TX reports active
// WAIT_TX   | waiting for TX done
// CLEAR     | zero operands/result, count the frame
module alu_frame_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int ALU_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_SIZE       = 8
) (
  input  logic                   i_Clock,
  input  logic                   i_reset_n,
  input  logic                   i_rx_done,
  input  logic [DATA_SIZE-1:0]   i_rx_data,
  input  logic [DATA_SIZE-1:0]   i_alu_result,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done,
  output logic [DATA_SIZE-1:0]   o_data_A,
  output logic [DATA_SIZE-1:0]   o_data_B,
  output logic [OPCODE_SIZE-1:0] o_data_OPCODE,
  output logic                   o_tx_start,
  output logic [DATA_SIZE-1:0]   o_tx_data,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic [CNT_SIZE-1:0]    o_frame_count,
  output logic [CNT_SIZE-1:0]    o_drop_count
);

  localparam int WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam int SETTLE_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [WD_W-1:0]     WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_SETTLE  = 3'd3,
    S_LAUNCH  = 3'd4,
    S_WAIT_TX = 3'd5,
    S_CLEAR   = 3'd6
  } state_t;

  state_t              state;
  logic                rx_prev;
  logic                rx_evt;
  logic                in_result_phase;
  logic [WD_W-1:0]     wd_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  // rx_prev resets high so a level already asserted at reset release is not a byte
  assign rx_evt          = i_rx_done & ~rx_prev;
  assign in_result_phase = (state == S_SETTLE) || (state == S_LAUNCH) ||
                           (state == S_WAIT_TX) || (state == S_CLEAR);

  always_ff @(posedge i_Clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_GET_A;
      rx_prev       <= 1'b1;
      wd_cnt        <= '0;
      settle_cnt    <= '0;
      o_data_A      <= '0;
      o_data_B      <= '0;
      o_data_OPCODE <= '0;
      o_tx_start    <= 1'b0;
      o_tx_data     <= '0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
      o_frame_count <= '0;
      o_drop_count  <= '0;
    end else begin
      rx_prev   <= i_rx_done;
      o_timeout <= 1'b0;
      case (state)
        S_GET_A: begin
          if (rx_evt) begin
            o_data_A <= i_rx_data;
            wd_cnt   <= '0;
            o_busy   <= 1'b1;
            state    <= S_GET_B;
          end
        end
        S_GET_B, S_GET_OP: begin
          // an accepted byte wins over watchdog expiry in the same cycle
          if (rx_evt) begin
            wd_cnt <= '0;
            if (state == S_GET_B) begin
              o_data_B <= i_rx_data;
              state    <= S_GET_OP;
            end else begin
              o_data_OPCODE <= i_rx_data[OPCODE_SIZE-1:0];
              settle_cnt    <= SETTLE_LOAD;
              state         <= S_SETTLE;
            end
          end else if (wd_cnt == WD_LAST) begin
            o_timeout     <= 1'b1;
            o_data_A      <= '0;
            o_data_B      <= '0;
            o_data_OPCODE <= '0;
            o_busy        <= 1'b0;
            state         <= S_GET_A;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            o_tx_data  <= i_alu_result;
            o_tx_start <= 1'b1;
            state      <= S_LAUNCH;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_LAUNCH: begin
          if (i_tx_active) begin
            o_tx_start <= 1'b0;
            state      <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (i_tx_done) state <= S_CLEAR;
        end
        S_CLEAR: begin
          o_data_A      <= '0;
          o_data_B      <= '0;
          o_data_OPCODE <= '0;
          o_tx_data     <= '0;
          o_frame_count <= o_frame_count + 1'b1;
          o_busy        <= 1'b0;
          state         <= S_GET_A;
        end
        default: begin
          o_data_A      <= '0;
          o_data_B      <= '0;
          o_data_OPCODE <= '0;
          o_tx_start    <= 1'b0;
          o_busy        <= 1'b0;
          state         <= S_GET_A;
        end
      endcase
      if (rx_evt && in_result_phase && (o_drop_count != '1))
        o_drop_count <= o_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl: frame flow, level-held RX, watchdog, drops,
// async reset and frame-counter wrap. A second instance with 2-bit counters shows saturation.
module tb_alu_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_active;
  logic       tx_done;

  logic [7:0] data_A, data_B, tx_data;
  logic [5:0] data_op;
  logic       tx_start, busy, timeout;
  logic [7:0] frame_count, drop_count;

  logic [7:0] d2_A, d2_B, d2_tx_data;
  logic [5:0] d2_op;
  logic       d2_tx_start, d2_busy, d2_timeout;
  logic [1:0] d2_frame_count, d2_drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  // ALU model: addition of the held operands
  assign alu_result = data_A + data_B;

  alu_frame_ctrl #(.DATA_SIZE(8), .OPCODE_SIZE(6), .ALU_LATENCY(2),
                   .TIMEOUT_CYCLES(16), .CNT_SIZE(8)) dut (
    .i_Clock(clk), .i_reset_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_result), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_data_A(data_A), .o_data_B(data_B), .o_data_OPCODE(data_op),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_timeout(timeout),
    .o_frame_count(frame_count), .o_drop_count(drop_count));

  alu_frame_ctrl #(.DATA_SIZE(8), .OPCODE_SIZE(6), .ALU_LATENCY(2),
                   .TIMEOUT_CYCLES(16), .CNT_SIZE(2)) dut2 (
    .i_Clock(clk), .i_reset_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_result), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_data_A(d2_A), .o_data_B(d2_B), .o_data_OPCODE(d2_op),
    .o_tx_start(d2_tx_start), .o_tx_data(d2_tx_data), .o_busy(d2_busy), .o_timeout(d2_timeout),
    .o_frame_count(d2_frame_count), .o_drop_count(d2_drop_count));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(1);
  endtask

  // Waits (bounded) for o_tx_start, then runs a minimal TX handshake through CLEAR.
  task automatic finish_tx(input string tag, input logic [7:0] exp_res);
    int k = 0;
    while (tx_start !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_start"}, tx_start, 1);
    check({tag, "_txdata"}, tx_data, exp_res);
    tx_active = 1'b1;
    tick(1);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(1);
    exp_frames++;
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    finish_tx(tag, exp_res);
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n     = 1'b0;
    rx_done   = 1'b1;
    rx_data   = 8'h55;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tick(2);
    check("rst_A", data_A, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_frames", frame_count, 0);
    rst_n = 1'b1;
    tick(3);
    // rx_done held high through reset is not a byte event
    check("held_through_rst_A", data_A, 0);
    check("held_through_rst_busy", busy, 0);
    rx_done = 1'b0;
    tick(1);

    // Basic frame
    send_byte(8'h05);
    check("basic_A", data_A, 8'h05);
    check("basic_busy", busy, 1);
    send_byte(8'h03);
    check("basic_B", data_B, 8'h03);
    send_byte(8'hE0);
    check("basic_op", data_op, 6'h20);
    check("basic_start_early", tx_start, 0);
    tick(1);
    check("basic_start", tx_start, 1);
    check("basic_txdata", tx_data, 8'h08);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("launch_ignores_done", tx_start, 1);
    tick(1);
    tx_active = 1'b1;
    tick(1);
    check("start_drops", tx_start, 0);
    tick(9);
    check("wait_tx_busy", busy, 1);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("pre_clear_frames", frame_count, 0);
    tick(1);
    exp_frames++;
    check("clear_A", data_A, 0);
    check("clear_B", data_B, 0);
    check("clear_op", data_op, 0);
    check("clear_txdata", tx_data, 0);
    check("clear_frames", frame_count, exp_frames);
    check("clear_busy", busy, 0);

    // Level-held rx_done: one capture per rising edge
    rx_data = 8'h11;
    rx_done = 1'b1;
    tick(2);
    rx_data = 8'hAA;
    tick(3);
    rx_done = 1'b0;
    tick(1);
    check("held_A", data_A, 8'h11);
    check("held_no_AA", data_B, 0);
    rx_data = 8'h22;
    rx_done = 1'b1;
    tick(5);
    rx_done = 1'b0;
    tick(1);
    check("held_B", data_B, 8'h22);
    rx_data = 8'h41;
    rx_done = 1'b1;
    tick(1);
    check("held_op", data_op, 6'h01);
    tick(4);
    rx_done = 1'b0;
    finish_tx("held", 8'h33);
    check("held_no_drops", drop_count, 0);
    check("held_frames", frame_count, exp_frames);

    // Watchdog expiry from GET_B
    send_byte(8'h7F);
    tick(14);
    check("to_not_yet", timeout, 0);
    check("to_A_held", data_A, 8'h7F);
    tick(1);
    check("to_pulse", timeout, 1);
    check("to_A_zero", data_A, 0);
    check("to_busy", busy, 0);
    tick(1);
    check("to_one_cycle", timeout, 0);
    check("to_frames", frame_count, exp_frames);

    // B in the expiry cycle is accepted; then expiry from GET_OP
    send_byte(8'h10);
    tick(14);
    rx_data = 8'h33;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    check("sim_no_timeout", timeout, 0);
    check("sim_B", data_B, 8'h33);
    check("sim_busy", busy, 1);
    tick(15);
    check("op_to_not_yet", timeout, 0);
    tick(1);
    check("op_to_pulse", timeout, 1);
    check("op_to_B_zero", data_B, 0);

    // Drops during WAIT_TX, saturation on the 2-bit instance
    tick(1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    tick(1);
    check("drop_start", tx_start, 1);
    tx_active = 1'b1;
    tick(1);
    tx_active = 1'b0;
    send_byte(8'hF1);
    send_byte(8'hF2);
    send_byte(8'hF3);
    check("drop_cnt3", drop_count, 3);
    check("drop_A", data_A, 8'h01);
    check("drop_B", data_B, 8'h02);
    check("drop_txdata", tx_data, 8'h03);
    send_byte(8'hF4);
    send_byte(8'hF5);
    check("drop_cnt5", drop_count, 5);
    check("drop_sat", d2_drop_count, 2'd3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(1);
    exp_frames++;
    check("drop_frames", frame_count, exp_frames);

    // Async reset in LAUNCH, mid-cycle
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'h20);
    tick(1);
    check("rstl_start", tx_start, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstl_start0", tx_start, 0);
    check("rstl_A0", data_A, 0);
    check("rstl_txdata0", tx_data, 0);
    check("rstl_busy0", busy, 0);
    check("rstl_frames0", frame_count, 0);
    check("rstl_drops0", drop_count, 0);
    tick(2);
    rst_n = 1'b1;
    exp_frames = 0;
    tick(1);
    run_frame("post_rst", 8'h0A, 8'h0B, 8'h20, 8'h15);
    check("post_rst_frames", frame_count, 1);

    // Frame counter wrap
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 255; i++) begin
      logic [7:0] a;
      a = i[7:0];
      run_frame("wrap", a, 8'h03, 8'h20, a + 8'h03);
    end
    check("wrap_255", frame_count, 8'd255);
    run_frame("wrap_last", 8'h40, 8'h40, 8'h20, 8'h80);
    check("wrap_0", frame_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
